sdram_cmd_monitor: RTL and testbench

//  Passive SDRAM-side command decoder and protocol checker. Sits on the
//  {cmd,ba,addr} bus driven by the init/refresh/arbiter blocks, in the device's

---
 rtl/sdram_cmd_monitor.sv | 215 +++++++++++++++++++++
 tb/tb_sdram_cmd_monitor.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_cmd_monitor.sv
// sdram_cmd_monitor: passive SDRAM command decoder and protocol checker.
// Tracks the power-up/init sequence, command spacing and the auto-refresh deadline.
module sdram_cmd_monitor #(
    parameter int unsigned T_POWERUP = 20000,
    parameter int unsigned T_RP      = 2,
    parameter int unsigned T_RFC     = 7,
    parameter int unsigned T_MRD     = 2,
    parameter int unsigned T_REFI    = 780,
    parameter int unsigned INIT_AREF = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  sdram_cmd,
    input  logic [1:0]  sdram_ba,
    input  logic [12:0] sdram_addr,
    output logic        init_done,
    output logic [12:0] mode_reg,
    output logic [15:0] aref_cnt,
    output logic        err_timing,
    output logic        err_seq,
    output logic        err_refi,
    output logic        err_any
);
    localparam int unsigned T_MAX = (T_RP > T_RFC) ? ((T_RP > T_MRD) ? T_RP : T_MRD)
                                                   : ((T_RFC > T_MRD) ? T_RFC : T_MRD);
    localparam int unsigned TW = $clog2(T_MAX) + 1;
    localparam int unsigned PW = $clog2(T_POWERUP + 1);
    localparam int unsigned RW = $clog2(T_REFI + 1);
    localparam int unsigned IW = $clog2(INIT_AREF + 1);

    localparam logic [TW-1:0] L_RP      = TW'(T_RP);
    localparam logic [TW-1:0] L_RFC     = TW'(T_RFC);
    localparam logic [TW-1:0] L_MRD     = TW'(T_MRD);
    localparam logic [TW-1:0] L_T_ONE   = TW'(1);
    localparam logic [PW-1:0] L_PWRUP   = PW'(T_POWERUP);
    localparam logic [PW-1:0] L_P_ONE   = PW'(1);
    localparam logic [RW-1:0] L_REFI    = RW'(T_REFI);
    localparam logic [RW-1:0] L_REFI_M1 = RW'(T_REFI - 1);
    localparam logic [RW-1:0] L_R_ONE   = RW'(1);
    localparam logic [IW-1:0] L_INIT    = IW'(INIT_AREF);
    localparam logic [IW-1:0] L_I_ONE   = IW'(1);

    typedef enum logic [1:0] {
        ST_PWRUP,
        ST_INIT_REF,
        ST_MRS_WAIT,
        ST_READY
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [TW-1:0] r_timer;
    logic [TW-1:0] w_timer_next;
    logic [PW-1:0] r_pwr_cnt;
    logic [PW-1:0] w_pwr_cnt_next;
    logic [IW-1:0] r_init_cnt;
    logic [IW-1:0] w_init_cnt_next;
    logic [RW-1:0] r_refi;
    logic [RW-1:0] w_refi_next;
    logic          r_init_done;
    logic [12:0]   r_mode;
    logic [15:0]   r_aref_cnt;
    logic          r_err_timing;
    logic          r_err_seq;
    logic          r_err_refi;
    logic          r_err_any;

    logic w_idle;
    logic w_active;
    logic w_is_pre;
    logic w_is_aref;
    logic w_is_mrs;
    logic w_pre_all;
    logic w_ba_zero;
    logic w_mode_load;
    logic w_set_done;
    logic w_err_timing;
    logic w_err_seq;
    logic w_err_refi;

    assign w_idle    = sdram_cmd[3] | (sdram_cmd[2:0] == 3'b111);
    assign w_active  = ~w_idle;
    assign w_is_pre  = (sdram_cmd == 4'b0010);
    assign w_is_aref = (sdram_cmd == 4'b0001);
    assign w_is_mrs  = (sdram_cmd == 4'b0000);
    assign w_pre_all = w_is_pre & sdram_addr[10];
    assign w_ba_zero = (sdram_ba == 2'b00);

    always_comb begin
        w_timer_next = r_timer;
        if (w_is_pre) begin
            w_timer_next = L_RP;
        end else if (w_is_aref) begin
            w_timer_next = L_RFC;
        end else if (w_is_mrs) begin
            w_timer_next = L_MRD;
        end else if (r_timer != '0) begin
            w_timer_next = r_timer - L_T_ONE;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_pwr_cnt_next  = r_pwr_cnt;
        w_init_cnt_next = r_init_cnt;
        w_refi_next     = r_refi;
        w_mode_load     = 1'b0;
        w_set_done      = 1'b0;
        w_err_seq       = 1'b0;
        w_err_refi      = 1'b0;
        w_err_timing    = w_active & (r_timer != '0);
        case (r_state)
            ST_PWRUP: begin
                // idle counter saturates at L_PWRUP, so "!=" reads as "not yet reached"
                if (w_idle) begin
                    if (r_pwr_cnt != L_PWRUP) begin
                        w_pwr_cnt_next = r_pwr_cnt + L_P_ONE;
                    end
                end else if (r_pwr_cnt != L_PWRUP) begin
                    w_err_timing = 1'b1;
                end else if (w_pre_all) begin
                    w_state_next    = ST_INIT_REF;
                    w_init_cnt_next = '0;
                end else begin
                    w_err_seq = 1'b1;
                end
            end
            ST_INIT_REF: begin
                if (w_is_aref) begin
                    if (r_init_cnt != L_INIT) begin
                        w_init_cnt_next = r_init_cnt + L_I_ONE;
                    end
                end else if (w_pre_all) begin
                    w_init_cnt_next = '0;
                end else if (w_is_mrs && w_ba_zero && (r_init_cnt == L_INIT)) begin
                    w_state_next = ST_MRS_WAIT;
                    w_mode_load  = 1'b1;
                end else if (w_active) begin
                    w_err_seq = 1'b1;
                end
            end
            ST_MRS_WAIT: begin
                if (w_timer_next == '0) begin
                    w_state_next = ST_READY;
                    w_set_done   = 1'b1;
                    w_refi_next  = '0;
                end
            end
            ST_READY: begin
                if (w_is_mrs) begin
                    if (w_ba_zero) begin
                        w_mode_load = 1'b1;
                    end else begin
                        w_err_seq = 1'b1;
                    end
                end
                // counter parks at L_REFI after the deadline so the pulse fires once
                if (w_is_aref) begin
                    w_refi_next = '0;
                end else if (r_refi != L_REFI) begin
                    w_refi_next = r_refi + L_R_ONE;
                    w_err_refi  = (r_refi == L_REFI_M1);
                end
            end
            default: begin
                w_state_next = ST_PWRUP;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_PWRUP;
            r_timer      <= '0;
            r_pwr_cnt    <= '0;
            r_init_cnt   <= '0;
            r_refi       <= '0;
            r_init_done  <= 1'b0;
            r_mode       <= '0;
            r_aref_cnt   <= '0;
            r_err_timing <= 1'b0;
            r_err_seq    <= 1'b0;
            r_err_refi   <= 1'b0;
            r_err_any    <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_timer      <= w_timer_next;
            r_pwr_cnt    <= w_pwr_cnt_next;
            r_init_cnt   <= w_init_cnt_next;
            r_refi       <= w_refi_next;
            if (w_mode_load) begin
                r_mode <= sdram_addr;
            end
            if (w_set_done) begin
                r_init_done <= 1'b1;
            end
            if (w_is_aref && (r_aref_cnt != '1)) begin
                r_aref_cnt <= r_aref_cnt + 16'd1;
            end
            r_err_timing <= w_err_timing;
            r_err_seq    <= w_err_seq;
            r_err_refi   <= w_err_refi;
            r_err_any    <= r_err_any | w_err_timing | w_err_seq | w_err_refi;
        end
    end

    assign init_done  = r_init_done;
    assign mode_reg   = r_mode;
    assign aref_cnt   = r_aref_cnt;
    assign err_timing = r_err_timing;
    assign err_seq    = r_err_seq;
    assign err_refi   = r_err_refi;
    assign err_any    = r_err_any;

endmodule

// File: tb/tb_sdram_cmd_monitor.sv
// tb_sdram_cmd_monitor: directed and random command streams against a
// cycle-stamp reference model of the SDRAM init/timing/refresh rules.
module tb_sdram_cmd_monitor;
    localparam int TPU   = 20;
    localparam int TRP   = 2;
    localparam int TRFC  = 7;
    localparam int TMRD  = 2;
    localparam int TREFI = 50;
    localparam int NAREF = 2;

    localparam logic [3:0] C_DESEL = 4'b1111;
    localparam logic [3:0] C_NOP   = 4'b0111;
    localparam logic [3:0] C_ACT   = 4'b0011;
    localparam logic [3:0] C_RD    = 4'b0101;
    localparam logic [3:0] C_WR    = 4'b0100;
    localparam logic [3:0] C_BST   = 4'b0110;
    localparam logic [3:0] C_PRE   = 4'b0010;
    localparam logic [3:0] C_AREF  = 4'b0001;
    localparam logic [3:0] C_MRS   = 4'b0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  cmd = C_NOP;
    logic [1:0]  ba = '0;
    logic [12:0] addr = '0;
    logic        init_done;
    logic [12:0] mode_reg;
    logic [15:0] aref_cnt;
    logic        err_timing;
    logic        err_seq;
    logic        err_refi;
    logic        err_any;

    always #5 clk = ~clk;

    sdram_cmd_monitor #(
        .T_POWERUP (TPU),
        .T_RP      (TRP),
        .T_RFC     (TRFC),
        .T_MRD     (TMRD),
        .T_REFI    (TREFI),
        .INIT_AREF (NAREF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sdram_cmd  (cmd),
        .sdram_ba   (ba),
        .sdram_addr (addr),
        .init_done  (init_done),
        .mode_reg   (mode_reg),
        .aref_cnt   (aref_cnt),
        .err_timing (err_timing),
        .err_seq    (err_seq),
        .err_refi   (err_refi),
        .err_any    (err_any)
    );

    int checks = 0;
    int errors = 0;
    int refi_seen = 0;

    // Reference model: time is an absolute cycle index; busy windows and the
    // refresh deadline are kept as cycle stamps rather than down/up counters.
    typedef enum int {M_PWRUP, M_INIT, M_MWAIT, M_READY} phase_t;
    phase_t      ph = M_PWRUP;
    int          t = 0;
    int          idle_cnt = 0;
    int          busy_until = -1;
    int          inits = 0;
    int          deadline = 0;
    int          m_aref = 0;
    bit          m_done = 0;
    bit          m_any = 0;
    bit          m_tim = 0;
    bit          m_seq = 0;
    bit          m_refi = 0;
    logic [12:0] m_mode = '0;

    function automatic void model_step(input logic r, input logic [3:0] c,
                                       input logic [1:0] b, input logic [12:0] a);
        bit     idle;
        bit     active;
        bit     busy;
        phase_t ph0;
        if (r) begin
            ph = M_PWRUP; idle_cnt = 0; busy_until = -1; inits = 0; deadline = 0;
            m_aref = 0; m_done = 0; m_any = 0; m_tim = 0; m_seq = 0; m_refi = 0;
            m_mode = '0;
            t++;
            return;
        end
        idle   = c[3] || (c == C_NOP);
        active = !idle;
        busy   = (t <= busy_until);
        ph0    = ph;
        m_tim  = active && (busy || (ph == M_PWRUP && idle_cnt < TPU));
        m_seq  = 0;
        m_refi = 0;
        case (ph)
            M_PWRUP: begin
                if (idle) idle_cnt++;
                else if (idle_cnt >= TPU) begin
                    if (c == C_PRE && a[10]) begin ph = M_INIT; inits = 0; end
                    else m_seq = 1;
                end
            end
            M_INIT: begin
                if (c == C_AREF) inits++;
                else if (c == C_PRE && a[10]) inits = 0;
                else if (c == C_MRS && b == 2'b00 && inits >= NAREF) begin
                    ph = M_MWAIT; m_mode = a;
                end else if (active) m_seq = 1;
            end
            M_READY: begin
                if (c == C_MRS) begin
                    if (b == 2'b00) m_mode = a; else m_seq = 1;
                end
                if (c == C_AREF) deadline = t + TREFI;
                else if (t == deadline) m_refi = 1;
            end
            default: ;
        endcase
        if (c == C_PRE)  busy_until = t + TRP;
        if (c == C_AREF) busy_until = t + TRFC;
        if (c == C_MRS)  busy_until = t + TMRD;
        if (ph0 == M_MWAIT && busy_until < t + 1) begin
            ph = M_READY; m_done = 1; deadline = t + TREFI;
        end
        if (c == C_AREF && m_aref < 65535) m_aref++;
        m_any = m_any | m_tim | m_seq | m_refi;
        t++;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, t);
        end
    endtask

    task automatic cyc(input logic [3:0] c, input logic [1:0] b, input logic [12:0] a);
        cmd = c; ba = b; addr = a;
        model_step(rst, c, b, a);
        @(posedge clk);
        #1;
        if (err_refi === 1'b1) refi_seen++;
        check("init_done",  32'(init_done),  32'(m_done));
        check("mode_reg",   32'(mode_reg),   32'(m_mode));
        check("aref_cnt",   32'(aref_cnt),   32'(m_aref));
        check("err_timing", 32'(err_timing), 32'(m_tim));
        check("err_seq",    32'(err_seq),    32'(m_seq));
        check("err_refi",   32'(err_refi),   32'(m_refi));
        check("err_any",    32'(err_any),    32'(m_any));
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) cyc(C_NOP, 2'b00, 13'h0000);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(C_NOP, 2'b00, 13'h0000);
        rst = 1'b0;
    endtask

    task automatic legal_init();
        nops(TPU);
        cyc(C_PRE, 2'b00, 13'h0400);
        nops(TRP);
        for (int i = 0; i < NAREF; i++) begin
            cyc(C_AREF, 2'b00, 13'h0000);
            nops(TRFC);
        end
        cyc(C_MRS, 2'b00, 13'h0032);
        nops(TMRD);
    endtask

    function automatic logic [3:0] rand_cmd(input int idle_pct);
        int unsigned r;
        r = $urandom_range(0, 99);
        if (r < idle_pct) return C_NOP;
        if (r < idle_pct + 5) return {1'b1, 3'($urandom_range(0, 7))};
        case ($urandom_range(0, 6))
            0: return C_ACT;
            1: return C_RD;
            2: return C_WR;
            3: return C_BST;
            4: return C_PRE;
            5: return C_AREF;
            default: return C_MRS;
        endcase
    endfunction

    task automatic rand_cycles(input int n, input int idle_pct);
        logic [1:0]  b;
        logic [12:0] a;
        for (int i = 0; i < n; i++) begin
            b = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
            a = 13'($urandom);
            cyc(rand_cmd(idle_pct), b, a);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Legal power-up and initialisation
        do_reset();
        check("rst_init_done", 32'(init_done), 32'd0);
        check("rst_aref_cnt", 32'(aref_cnt), 32'd0);
        nops(TPU);
        cyc(C_PRE, 2'b00, 13'h0400);
        nops(TRP);
        for (int i = 0; i < NAREF; i++) begin
            cyc(C_AREF, 2'b00, 13'h0000);
            nops(TRFC);
        end
        cyc(C_MRS, 2'b00, 13'h0032);
        nops(1);
        check("t1_done_early", 32'(init_done), 32'd0);
        nops(1);
        check("t1_done", 32'(init_done), 32'd1);
        check("t1_mode", 32'(mode_reg), 32'h0032);
        check("t1_arefs", 32'(aref_cnt), 32'd2);
        check("t1_any", 32'(err_any), 32'd0);

        // tRFC violation in READY
        cyc(C_AREF, 2'b00, 13'h0000);
        nops(2);
        cyc(C_ACT, 2'b01, 13'h0123);
        check("t3_timing", 32'(err_timing), 32'd1);
        check("t3_any", 32'(err_any), 32'd1);
        nops(TRFC);

        // Refresh deadline: regular AREFs, then a single missed-deadline pulse
        nops(5);
        refi_seen = 0;
        for (int i = 0; i < 3; i++) begin
            cyc(C_AREF, 2'b00, 13'h0000);
            nops(39);
        end
        check("t5_no_refi", 32'(refi_seen), 32'd0);
        refi_seen = 0;
        nops(120);
        check("t5_one_refi", 32'(refi_seen), 32'd1);

        // Early command during power-up
        do_reset();
        nops(5);
        cyc(C_PRE, 2'b00, 13'h0400);
        check("t2_timing", 32'(err_timing), 32'd1);
        check("t2_seq", 32'(err_seq), 32'd0);
        check("t2_any", 32'(err_any), 32'd1);
        legal_init();
        check("t2_recover", 32'(init_done), 32'd1);

        // Sequence errors during init
        do_reset();
        nops(TPU);
        cyc(C_PRE, 2'b00, 13'h0400);
        nops(TRP);
        cyc(C_AREF, 2'b00, 13'h0000);
        nops(TRFC);
        cyc(C_MRS, 2'b00, 13'h0032);
        check("t4_early_mrs", 32'(err_seq), 32'd1);
        nops(3);
        check("t4_not_done", 32'(init_done), 32'd0);
        cyc(C_AREF, 2'b00, 13'h0000);
        nops(TRFC);
        cyc(C_MRS, 2'b01, 13'h1fff);
        check("t4_ba_mrs", 32'(err_seq), 32'd1);
        check("t4_mode_keep", 32'(mode_reg), 32'h0000);
        nops(TMRD);
        cyc(C_MRS, 2'b00, 13'h0123);
        nops(TMRD);
        check("t4_done", 32'(init_done), 32'd1);
        check("t4_mode", 32'(mode_reg), 32'h0123);

        // Reset in the middle of init, after an error
        do_reset();
        nops(TPU);
        cyc(C_PRE, 2'b00, 13'h0400);
        nops(TRP);
        cyc(C_AREF, 2'b00, 13'h0000);
        cyc(C_ACT, 2'b00, 13'h0000);
        nops(3);
        do_reset();
        check("t6_any", 32'(err_any), 32'd0);
        check("t6_arefs", 32'(aref_cnt), 32'd0);
        check("t6_timing", 32'(err_timing), 32'd0);
        check("t6_seq", 32'(err_seq), 32'd0);
        legal_init();
        check("t6_done", 32'(init_done), 32'd1);
        check("t6_arefs2", 32'(aref_cnt), 32'd2);

        // Random traffic from reset, then random traffic after a legal init
        do_reset();
        rand_cycles(500, 80);
        do_reset();
        legal_init();
        rand_cycles(800, 70);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
